prog_counter_gen2: RTL and testbench

Parametrised successor to the team's 8-bit programmable up/down counter. It counts rising edges of an asynchronous external strobe (clk_in) in the clk domain, after synchronisation and edge detection, and supports a configurable width and a runtime terminal value (limit). It adds an edge prescaler, three overflow modes (wrap, saturate, one-shot), a terminal-count pulse and a sticky done flag. It sits behind the chip top-level; count drives the bidirectional pins when oe is high.

---
 rtl/prog_counter_gen2_pkg.sv | 11 +
 rtl/prog_counter_gen2_if.sv | 31 +++
 rtl/prog_counter_gen2_edge_sync.sv | 36 +++
 rtl/prog_counter_gen2.sv | 84 ++++++++
 tb/tb_prog_counter_gen2.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/prog_counter_gen2_pkg.sv
// prog_counter_pkg: shared overflow-mode encodings for prog_counter_gen2.
//   MODE_WRAP    - roll over at the terminal value
//   MODE_SAT     - hold at the terminal value
//   MODE_ONESHOT - hold at the terminal value and raise sticky done
//   MODE_RSVD    - reserved encoding, behaves as wrap
package prog_counter_pkg;
   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   localparam logic [1:0] MODE_RSVD    = 2'b11;
endpackage

// File: rtl/prog_counter_gen2_if.sv
// prog_counter_gen2_if: control/status bundle of the programmable counter.
//   master : drives clk_in, enable, load, load_val, up_down, mode, prescale, limit;
//            observes count, tc, done, oe
//   slave  : the counter side of the same signals
interface prog_counter_gen2_if #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
);
   logic                  clk_in;
   logic                  enable;
   logic                  load;
   logic                  up_down;
   logic [1:0]            mode;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      limit;
   logic [WIDTH-1:0]      load_val;
   logic [WIDTH-1:0]      count;
   logic                  tc;
   logic                  done;
   logic                  oe;

   modport master (
      output clk_in, enable, load, up_down, mode, prescale, limit, load_val,
      input  count, tc, done, oe
   );

   modport slave (
      input  clk_in, enable, load, up_down, mode, prescale, limit, load_val,
      output count, tc, done, oe
   );
endinterface

// File: rtl/prog_counter_gen2_edge_sync.sv
// edge_sync: multi-flop synchroniser for an asynchronous strobe plus a
// rising-edge detector in the clk domain.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   async_in in  asynchronous strobe
//   edge_out out one-cycle pulse after a synchronised rising edge
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_out
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   // Combinational from the last stage so the step lands on the
   // (SYNC_STAGES+1)th clk edge after clk_in is first sampled high.
   assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/prog_counter_gen2.sv
// prog_counter_gen2: programmable up/down counter of external strobe edges
// with prescaler, wrap/saturate/one-shot overflow, terminal pulse and done.
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   bus   slave modport: clk_in, enable, load, load_val, up_down, mode,
//         prescale, limit in; count, tc, done, oe out
module prog_counter_gen2
   import prog_counter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   prog_counter_gen2_if.slave  bus
);
   logic                  edge_det;
   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic                  tc_q, tc_d;
   logic                  done_q, done_d;
   logic                  wrap_m, oneshot, qual, step, at_end;
   logic [WIDTH-1:0]      term, step_val;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.clk_in),
      .edge_out (edge_det)
   );

   always_comb begin
      wrap_m   = (bus.mode == MODE_WRAP) || (bus.mode == MODE_RSVD);
      oneshot  = bus.mode == MODE_ONESHOT;
      qual     = edge_det & bus.enable & ~bus.load;
      // A finished one-shot still advances the prescaler but never steps.
      step     = qual && (pcnt_q == bus.prescale) && !(oneshot && done_q);
      term     = bus.up_down ? bus.limit : '0;
      // Up-counting treats anything at or above limit as terminal, so a
      // count loaded above limit wraps straight to zero.
      at_end   = bus.up_down ? (count_q >= bus.limit) : (count_q == '0);
      step_val = at_end ? (wrap_m ? (bus.up_down ? '0 : bus.limit) : count_q)
                        : (bus.up_down ? count_q + 1'b1 : count_q - 1'b1);
      count_d  = count_q;
      pcnt_d   = pcnt_q;
      tc_d     = 1'b0;
      done_d   = done_q & oneshot;
      if (bus.load) begin
         count_d = bus.load_val;
         pcnt_d  = '0;
         done_d  = 1'b0;
      end else begin
         if (qual)
            pcnt_d = (pcnt_q == bus.prescale) ? '0 : pcnt_q + 1'b1;
         if (step) begin
            count_d = step_val;
            // Held saturation and wrap away from the terminal give no pulse.
            tc_d    = (step_val == term) && (step_val != count_q);
            if (oneshot && step_val == term)
               done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         pcnt_q  <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         pcnt_q  <= pcnt_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.done  = done_q;
   assign bus.oe    = bus.enable & ~bus.load;
endmodule

// File: tb/tb_prog_counter_gen2.sv
// tb_prog_counter_gen2: directed table-driven bench for prog_counter_gen2.
module tb_prog_counter_gen2;
   import prog_counter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prog_counter_gen2_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

   prog_counter_gen2 #(.WIDTH(8), .SYNC_STAGES(2), .PRESCALE_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      nm;
      logic       ld;
      logic [7:0] lv;
      logic [1:0] md;
      logic       ud;
      logic [7:0] lim;
      logic [7:0] ec;
      logic       etc;
      logic       edn;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic ld, input logic [7:0] lv,
                      input logic [1:0] md, input logic ud, input logic [7:0] lim,
                      input logic [7:0] ec, input logic etc, input logic edn);
      vt.push_back('{nm, ld, lv, md, ud, lim, ec, etc, edn});
   endtask

   // One clk_in pulse; returns count just before the expected update edge,
   // the outputs right after it and tc one cycle later.
   task automatic pulse(output logic [7:0] cb, output logic [7:0] ca,
                        output logic ta, output logic da, output logic tn);
      @(negedge clk) bus.clk_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 cb = bus.count;
      @(posedge clk);
      #1 ca = bus.count; ta = bus.tc; da = bus.done;
      @(posedge clk);
      #1 tn = bus.tc;
      @(negedge clk) bus.clk_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_load(input logic [7:0] v);
      @(negedge clk) begin bus.load = 1'b1; bus.load_val = v; end
      @(negedge clk) bus.load = 1'b0;
   endtask

   logic [7:0] cb, ca, prev_c;
   logic       ta, da, tn;

   initial begin
      bus.clk_in = 1'b0; bus.enable = 1'b1; bus.load = 1'b0; bus.up_down = 1'b1;
      bus.mode = MODE_WRAP; bus.prescale = 4'd0; bus.limit = 8'hFF; bus.load_val = 8'h00;

      add("wr_ld", 1, 8'hFD, MODE_WRAP,    1, 8'hFF, 8'hFD, 0, 0);
      add("wr_fe", 0, 8'h00, MODE_WRAP,    1, 8'hFF, 8'hFE, 0, 0);
      add("wr_ff", 0, 8'h00, MODE_WRAP,    1, 8'hFF, 8'hFF, 1, 0);
      add("wr_00", 0, 8'h00, MODE_WRAP,    1, 8'hFF, 8'h00, 0, 0);
      add("sd_ld", 1, 8'h02, MODE_SAT,     0, 8'hFF, 8'h02, 0, 0);
      add("sd_01", 0, 8'h00, MODE_SAT,     0, 8'hFF, 8'h01, 0, 0);
      add("sd_00", 0, 8'h00, MODE_SAT,     0, 8'hFF, 8'h00, 1, 0);
      add("sd_h1", 0, 8'h00, MODE_SAT,     0, 8'hFF, 8'h00, 0, 0);
      add("sd_h2", 0, 8'h00, MODE_SAT,     0, 8'hFF, 8'h00, 0, 0);
      add("os_ld", 1, 8'h03, MODE_ONESHOT, 1, 8'h05, 8'h03, 0, 0);
      add("os_04", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h04, 0, 0);
      add("os_05", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h05, 1, 1);
      add("os_h1", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h05, 0, 1);
      add("os_h2", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h05, 0, 1);
      add("os_rl", 1, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h00, 0, 0);
      add("os_01", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h01, 0, 0);
      add("ab_ld", 1, 8'h20, MODE_WRAP,    1, 8'h10, 8'h20, 0, 0);
      add("ab_wr", 0, 8'h00, MODE_WRAP,    1, 8'h10, 8'h00, 0, 0);
      add("l0_ld", 1, 8'h00, MODE_WRAP,    1, 8'h00, 8'h00, 0, 0);
      add("l0_wr", 0, 8'h00, MODE_WRAP,    1, 8'h00, 8'h00, 0, 0);
      add("l0_st", 0, 8'h00, MODE_SAT,     1, 8'h00, 8'h00, 0, 0);
      add("dw_ld", 1, 8'h01, MODE_WRAP,    0, 8'h07, 8'h01, 0, 0);
      add("dw_00", 0, 8'h00, MODE_WRAP,    0, 8'h07, 8'h00, 1, 0);
      add("dw_wr", 0, 8'h00, MODE_WRAP,    0, 8'h07, 8'h07, 0, 0);
      add("dw_06", 0, 8'h00, MODE_WRAP,    0, 8'h07, 8'h06, 0, 0);
      add("rs_ld", 1, 8'h00, MODE_RSVD,    0, 8'h09, 8'h00, 0, 0);
      add("rs_wr", 0, 8'h00, MODE_RSVD,    0, 8'h09, 8'h09, 0, 0);
      add("mc_ld", 1, 8'h04, MODE_ONESHOT, 1, 8'h05, 8'h04, 0, 0);
      add("mc_05", 0, 8'h00, MODE_ONESHOT, 1, 8'h05, 8'h05, 1, 1);

      // Reset with strobe activity, then release: no phantom count.
      repeat (3) @(negedge clk) bus.clk_in = ~bus.clk_in;
      @(negedge clk) bus.clk_in = 1'b0;
      chk("rst_count", bus.count, 8'h00);
      chk("rst_tc", bus.tc, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_oe", bus.oe, 1'b1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_idle", bus.count, 8'h00);
      pulse(cb, ca, ta, da, tn);
      chk("rst_first", ca, 8'h01);
      prev_c = 8'h01;

      foreach (vt[i]) begin
         @(negedge clk) begin
            bus.mode = vt[i].md; bus.up_down = vt[i].ud; bus.limit = vt[i].lim;
         end
         if (vt[i].ld) begin
            do_load(vt[i].lv);
            chk({vt[i].nm, "_count"}, bus.count, vt[i].ec);
         end else begin
            pulse(cb, ca, ta, da, tn);
            chk({vt[i].nm, "_lat"}, cb, prev_c);
            chk({vt[i].nm, "_count"}, ca, vt[i].ec);
            chk({vt[i].nm, "_tcfall"}, tn, 1'b0);
            ta = ta; da = da;
         end
         chk({vt[i].nm, "_tc"}, vt[i].ld ? bus.tc : ta, vt[i].etc);
         chk({vt[i].nm, "_done"}, vt[i].ld ? bus.done : da, vt[i].edn);
         prev_c = vt[i].ec;
      end

      // Leaving one-shot mode clears done.
      @(negedge clk) bus.mode = MODE_SAT;
      @(negedge clk);
      chk("mc_clr", bus.done, 1'b0);
      chk("mc_cnt", bus.count, 8'h05);

      // Prescale by 3, then gated by enable.
      @(negedge clk) begin
         bus.mode = MODE_WRAP; bus.up_down = 1'b1; bus.limit = 8'hFF; bus.prescale = 4'd2;
      end
      do_load(8'h00);
      repeat (2) pulse(cb, ca, ta, da, tn);
      chk("ps_2", bus.count, 8'h00);
      pulse(cb, ca, ta, da, tn);
      chk("ps_3", bus.count, 8'h01);
      repeat (6) pulse(cb, ca, ta, da, tn);
      chk("ps_9", bus.count, 8'h03);
      @(negedge clk) bus.enable = 1'b0;
      #1 chk("en_oe", bus.oe, 1'b0);
      repeat (3) pulse(cb, ca, ta, da, tn);
      chk("en_hold", bus.count, 8'h03);
      @(negedge clk) bus.enable = 1'b1;

      // Load colliding with a detected edge; prescaler must restart.
      @(negedge clk) bus.prescale = 4'd1;
      do_load(8'h00);
      pulse(cb, ca, ta, da, tn);
      chk("co_pre", bus.count, 8'h00);
      @(negedge clk) bus.clk_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) begin bus.load = 1'b1; bus.load_val = 8'h10; end
      #1 chk("co_oe", bus.oe, 1'b0);
      @(negedge clk) bus.load = 1'b0;
      chk("co_load", bus.count, 8'h10);
      chk("co_tc", bus.tc, 1'b0);
      repeat (5) @(negedge clk);
      chk("co_hold", bus.count, 8'h10);
      bus.clk_in = 1'b0;
      repeat (3) @(negedge clk);
      pulse(cb, ca, ta, da, tn);
      chk("co_pcnt", bus.count, 8'h10);
      pulse(cb, ca, ta, da, tn);
      chk("co_step", bus.count, 8'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
